// File: rtl/score_bcd_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score_bcd_display_if                                         |
// | Description : Frame trigger, score input and BCD display result bundle     |
// |               for score_bcd_display.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface score_bcd_display_if #(
   parameter int SCORE_W = 11,
   parameter int DIGITS  = 4
);
   logic                  frame_vs;
   logic [SCORE_W-1:0]    score;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     digit_blank;
   logic                  overflow;
   logic                  busy;
   logic                  done;

   // Game side: supplies the frame trigger and score, consumes the digits
   modport master (
      output frame_vs, score,
      input  bcd, digit_blank, overflow, busy, done
   );

   // Converter side
   modport slave (
      input  frame_vs, score,
      output bcd, digit_blank, overflow, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/score_bcd_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score_bcd_display                                            |
// | Description : Once-per-frame binary score to BCD conversion (iterative     |
// |               double-dabble, one bit per clock) with leading-zero blank    |
// |               flags and saturation to all 9s on overflow.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module score_bcd_display #(
   parameter int SCORE_W = 11,
   parameter int DIGITS  = 4
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   score_bcd_display_if.slave   bus
);

   localparam int          CNT_W     = $clog2(SCORE_W + 1);
   localparam int          BCD_W     = 4 * DIGITS;
   localparam logic [31:0] OVF_LIMIT = 32'(10 ** DIGITS);
   localparam logic [BCD_W-1:0]  ALL_NINES   = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t               state_q, state_d;

   logic                 vs_s1_q, vs_s2_q, vs_s3_q;
   logic                 vs_rise;

   logic [SCORE_W-1:0]   bin_sr_q, bin_sr_d;
   logic [BCD_W-1:0]     scratch_q, scratch_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [DIGITS-1:0]    blank_q, blank_d;
   logic                 overflow_q, overflow_d;
   logic                 done_q, done_d;

   logic [BCD_W-1:0]     adj;
   logic [BCD_W-1:0]     bcd_new;
   logic [DIGITS-1:0]    blank_new;
   logic                 score_ovf;

   // frame_vs is asynchronous to Clk: synchronise, then keep one more stage for edge detect
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_s1_q <= 1'b0;
         vs_s2_q <= 1'b0;
         vs_s3_q <= 1'b0;
      end else begin
         vs_s1_q <= bus.frame_vs;
         vs_s2_q <= vs_s1_q;
         vs_s3_q <= vs_s2_q;
      end
   end

   assign vs_rise   = vs_s2_q & ~vs_s3_q;
   assign score_ovf = (32'(bus.score) >= OVF_LIMIT);

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift
   for (genvar n = 0; n < DIGITS; n++) begin : g_adj
      assign adj[4*n +: 4] = (scratch_q[4*n +: 4] >= 4'd5) ? (scratch_q[4*n +: 4] + 4'd3)
                                                            : scratch_q[4*n +: 4];
   end

   // Value about to be latched; saturates so the display reads all 9s
   assign bcd_new = ovf_q ? ALL_NINES : scratch_q;

   // Digit i is blank when it and every more significant digit are zero; digit 0 always shows
   for (genvar i = 0; i < DIGITS; i++) begin : g_blank
      if (i == 0) begin : g_lsd
         assign blank_new[i] = 1'b0;
      end else begin : g_upper
         assign blank_new[i] = (bcd_new[BCD_W-1:4*i] == '0);
      end
   end

   // State and datapath registers; reset abandons any conversion in flight
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         bin_sr_q   <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         blank_q    <= BLANK_RESET;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_sr_q   <= bin_sr_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         blank_q    <= blank_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // Next-state and datapath updates; a vs rise outside IDLE is dropped, not queued
   always_comb begin
      state_d    = state_q;
      bin_sr_d   = bin_sr_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (vs_rise) begin
               bin_sr_d  = bus.score;
               scratch_d = '0;
               cnt_d     = CNT_W'(SCORE_W);
               ovf_d     = score_ovf;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Bits pushed past the top of scratch only occur in the overflow case
            scratch_d = {adj[BCD_W-2:0], bin_sr_q[SCORE_W-1]};
            bin_sr_d  = {bin_sr_q[SCORE_W-2:0], 1'b0};
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            bcd_d      = bcd_new;
            blank_d    = blank_new;
            overflow_d = ovf_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.bcd         = bcd_q;
   assign bus.digit_blank = blank_q;
   assign bus.overflow    = overflow_q;
   assign bus.done        = done_q;
   assign bus.busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_display.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_score_bcd_display                                         |
// | Description : Directed self-checking bench for score_bcd_display, with a   |
// |               4-digit and a 3-digit instance sharing clock and reset.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_score_bcd_display;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   score_bcd_display_if #(.SCORE_W(11), .DIGITS(4)) bus4 ();
   score_bcd_display_if #(.SCORE_W(11), .DIGITS(3)) bus3 ();

   score_bcd_display #(.SCORE_W(11), .DIGITS(4)) dut4 (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus4.slave)
   );

   score_bcd_display #(.SCORE_W(11), .DIGITS(3)) dut3 (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus3.slave)
   );

   always #5 Clk = ~Clk;

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // Raise frame_vs before edge 0 with score s, wait for done (bounded), then drop frame_vs.
   // lat = edge index at which done was seen (-1 on timeout); busy_cnt = cycles busy; done_cnt = done pulses seen.
   task automatic run_frame(input bit use3, input logic [10:0] s,
                            output int lat, output int busy_cnt, output int done_cnt);
      lat = -1; busy_cnt = 0; done_cnt = 0;
      @(negedge Clk);
      if (use3) begin bus3.score = s; bus3.frame_vs = 1'b1; end
      else      begin bus4.score = s; bus4.frame_vs = 1'b1; end
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (use3 ? bus3.busy : bus4.busy) busy_cnt++;
         if (use3 ? bus3.done : bus4.done) begin
            lat = k;
            done_cnt++;
         end
      end
      bus3.frame_vs = 1'b0;
      bus4.frame_vs = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         if (use3 ? bus3.done : bus4.done) done_cnt++;
      end
   endtask

   task automatic test_reset;
      Reset_n = 1'b0;
      bus4.frame_vs = 1'b0; bus4.score = '0;
      bus3.frame_vs = 1'b0; bus3.score = '0;
      repeat (3) @(negedge Clk);
      total++; if (bus4.bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h required 0000", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b1110) begin bad++; $display("FAIL reset_blank: got %b required 1110", bus4.digit_blank); end
      total++; if (bus4.overflow !== 1'b0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         bad++; $display("FAIL reset_flags: got ovf=%b busy=%b done=%b required 0 0 0", bus4.overflow, bus4.busy, bus4.done); end
      total++; if (bus3.digit_blank !== 3'b110) begin bad++; $display("FAIL reset_blank3: got %b required 110", bus3.digit_blank); end
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      total++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", bus4.busy, bus4.done); end
   endtask

   task automatic test_zero;
      int lat, bc, dc;
      run_frame(1'b0, 11'd0, lat, bc, dc);
      total++; if (lat !== 14) begin bad++; $display("FAIL zero_latency: got %0d required 14", lat); end
      total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_pulses: got %0d required 1", dc); end
      total++; if (bus4.bcd !== 16'h0000) begin bad++; $display("FAIL zero_bcd: got %h required 0000", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b1110) begin bad++; $display("FAIL zero_blank: got %b required 1110", bus4.digit_blank); end
      total++; if (bus4.overflow !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b required 0", bus4.overflow); end
   endtask

   task automatic test_values;
      int lat, bc, dc;
      run_frame(1'b0, 11'd1234, lat, bc, dc);
      total++; if (bus4.bcd !== 16'h1234) begin bad++; $display("FAIL v1234_bcd: got %h required 1234", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b0000) begin bad++; $display("FAIL v1234_blank: got %b required 0000", bus4.digit_blank); end
      run_frame(1'b0, 11'd57, lat, bc, dc);
      total++; if (bus4.bcd !== 16'h0057) begin bad++; $display("FAIL v57_bcd: got %h required 0057", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b1100) begin bad++; $display("FAIL v57_blank: got %b required 1100", bus4.digit_blank); end
      // Outputs hold between frames
      repeat (20) @(negedge Clk);
      total++; if (bus4.bcd !== 16'h0057 || bus4.done !== 1'b0) begin
         bad++; $display("FAIL v57_hold: got bcd=%h done=%b required 0057 0", bus4.bcd, bus4.done); end
   endtask

   task automatic test_max;
      int lat, bc, dc;
      run_frame(1'b0, 11'd2047, lat, bc, dc);
      total++; if (bus4.bcd !== 16'h2047) begin bad++; $display("FAIL max_bcd: got %h required 2047", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b0000) begin bad++; $display("FAIL max_blank: got %b required 0000", bus4.digit_blank); end
      total++; if (bc !== 12) begin bad++; $display("FAIL max_busy_cycles: got %0d required 12", bc); end
      total++; if (bus4.overflow !== 1'b0) begin bad++; $display("FAIL max_ovf: got %b required 0", bus4.overflow); end
   endtask

   task automatic test_overflow;
      int lat, bc, dc;
      run_frame(1'b1, 11'd1500, lat, bc, dc);
      total++; if (lat !== 14) begin bad++; $display("FAIL ovf_latency: got %0d required 14", lat); end
      total++; if (bus3.bcd !== 12'h999) begin bad++; $display("FAIL ovf_bcd: got %h required 999", bus3.bcd); end
      total++; if (bus3.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b required 1", bus3.overflow); end
      total++; if (bus3.digit_blank !== 3'b000) begin bad++; $display("FAIL ovf_blank: got %b required 000", bus3.digit_blank); end
      run_frame(1'b1, 11'd42, lat, bc, dc);
      total++; if (bus3.bcd !== 12'h042) begin bad++; $display("FAIL v42_bcd: got %h required 042", bus3.bcd); end
      total++; if (bus3.overflow !== 1'b0) begin bad++; $display("FAIL v42_ovf: got %b required 0", bus3.overflow); end
      total++; if (bus3.digit_blank !== 3'b100) begin bad++; $display("FAIL v42_blank: got %b required 100", bus3.digit_blank); end
      // Exactly at the limit
      run_frame(1'b1, 11'd1000, lat, bc, dc);
      total++; if (bus3.bcd !== 12'h999 || bus3.overflow !== 1'b1) begin
         bad++; $display("FAIL v1000_ovf: got bcd=%h ovf=%b required 999 1", bus3.bcd, bus3.overflow); end
      run_frame(1'b1, 11'd999, lat, bc, dc);
      total++; if (bus3.bcd !== 12'h999 || bus3.overflow !== 1'b0) begin
         bad++; $display("FAIL v999_noovf: got bcd=%h ovf=%b required 999 0", bus3.bcd, bus3.overflow); end
   endtask

   task automatic test_back_to_back;
      int dc;
      dc = 0;
      @(negedge Clk);
      bus4.score = 11'd1234; bus4.frame_vs = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (bus4.done) dc++;
         if (k == 2) begin bus4.frame_vs = 1'b0; bus4.score = 11'd99; end
         if (k == 3) bus4.frame_vs = 1'b1;
      end
      total++; if (dc !== 1) begin bad++; $display("FAIL b2b_done_pulses: got %0d required 1", dc); end
      total++; if (bus4.bcd !== 16'h1234) begin bad++; $display("FAIL b2b_bcd: got %h required 1234", bus4.bcd); end
      bus4.frame_vs = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_reset_mid_shift;
      int lat, bc, dc;
      run_frame(1'b0, 11'd57, lat, bc, dc);
      total++; if (bus4.bcd !== 16'h0057) begin bad++; $display("FAIL pre_rst_bcd: got %h required 0057", bus4.bcd); end
      @(negedge Clk);
      bus4.score = 11'd1234; bus4.frame_vs = 1'b1;
      repeat (6) @(negedge Clk);
      total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL mid_shift_busy: got %b required 1", bus4.busy); end
      #2;
      Reset_n = 1'b0;
      bus4.frame_vs = 1'b0;
      #1;
      total++; if (bus4.bcd !== 16'h0000) begin bad++; $display("FAIL rst_mid_bcd: got %h required 0000", bus4.bcd); end
      total++; if (bus4.digit_blank !== 4'b1110) begin bad++; $display("FAIL rst_mid_blank: got %b required 1110", bus4.digit_blank); end
      total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b required 0", bus4.busy); end
      @(negedge Clk);
      Reset_n = 1'b1;
      dc = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (bus4.done) dc++;
      end
      total++; if (dc !== 0) begin bad++; $display("FAIL rst_no_done: got %0d required 0", dc); end
      run_frame(1'b0, 11'd99, lat, bc, dc);
      total++; if (bus4.bcd !== 16'h0099 || bus4.digit_blank !== 4'b1100) begin
         bad++; $display("FAIL post_rst_99: got bcd=%h blank=%b required 0099 1100", bus4.bcd, bus4.digit_blank); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_values();
      test_max();
      test_overflow();
      test_back_to_back();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
